issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
// Dual-dispatch, dual-issue, age-ordered (compacting) issue queue, directly downstream of busy_table.
// Accepts up to 2 renamed insts/cycle from decode with busy_table src-ready bits; tracks per-src readiness.
// Selects the 2 oldest fully-ready entries for the execute ports.
// Broadcasts fired dests back to busy_table (sel_inst*_dest); wakes sources on select and writeback dests.
// PARAMETERS
// DEPTH      8   entry count; >= 4
// ADDR_W     5   architectural register address width (REG_NUM = 2**ADDR_W)
// PAYLOAD_W  64  opaque decoded-instruction payload carried through unchanged
// PORTS
// clk              in   1          clock
// reset            in   1          synchronous, active-high
// flush            in   1          discard all entries (branch mispredict / exception)
// disp_ready       out  1          queue can accept 2 insts this cycle
// disp_valid1/2    in   1 each     dispatch slot valid; slot1 is older; valid2 only with valid1
// disp_src1_1/2    in   ADDR_W     slot1 source regs
// disp_src2_1/2    in   ADDR_W     slot2 source regs
// disp_rdy1_1/2    in   1 each     slot1 src ready, from busy_table
// disp_rdy2_1/2    in   1 each     slot2 src ready, from busy_table
// disp_dest1/2     in   ADDR_W     dest reg
// disp_we1/2       in   1 each     dest written
// disp_payload1/2  in   PAYLOAD_W  payload
// iss_valid1/2     out  1 each     issue port has an inst
// iss_ready1/2     in   1 each     execute port accepts
// iss_payload1/2   out  PAYLOAD_W  issued payload
// sel_dest1/2      out  ADDR_W     dest of fired inst if we=1, else 0 (to busy_table)
// wb_dest1/2       in   ADDR_W     writeback dests; 0 = none
// BEHAVIOUR
// - Entry: valid, src1/src2 addr, rdy1, rdy2, dest, we, payload. Index 0 is oldest; ages are contiguous.
// - Entry ready = valid & rdy1 & rdy2.
// - Select: port1 = oldest ready entry; port2 = next-oldest ready entry. Purely combinational from state.
// - Fire: port k fires when iss_valid_k & iss_ready_k. Ports fire independently.
//   - Fired entries are removed; survivors compact toward index 0, order preserved.
// - sel_dest_k = (fire_k & we) ? dest : 0.
// - Wakeup set W = {sel_dest1, sel_dest2, wb_dest1, wb_dest2}, excluding 0.
//   - Source matching any member of W: rdy <= 1 at the clock edge.
//   - Applies to resident entries and to entries being dispatched this cycle (dispatched rdy = disp_rdy | match).
//   - Source reg 0 is always ready.
// - Dispatch is registered: accepted insts are appended after survivors at the edge.
//   - Never selectable in their dispatch cycle (min dispatch-to-issue latency = 1 cycle).
// - disp_ready = (count <= DEPTH-2); count is registered. Dispatch while disp_ready=0 is ignored.
//   - Upstream stalls when disp_ready=0.
// - count_next = count - fire1 - fire2 + (accepted dispatches). 0 <= count <= DEPTH always.
// - Full: no acceptance. Same-cycle fire does not raise disp_ready until the next cycle.
// - Empty: iss_valid1/2 = 0, sel_dest1/2 = 0.
// - flush or reset (flush has priority over dispatch/fire):
//   - all valid <= 0, count <= 0.
//   - In the flush cycle, fires are suppressed and sel_dest1/2 forced to 0.
// - Reset values: iss_valid1/2 = 0, sel_dest1/2 = 0, disp_ready = 1, iss_payload = 0 (entries zeroed).
// - Reset or flush mid-operation: queued and dispatching insts dropped; no issue next cycle.
// TESTING
// - Dispatch A(src r1,r2 ready, dest r3) + B(src r3 not ready) -> next cycle A on port1, sel_dest1=3.
//   - Cycle after that, B issues.
// - 3 ready insts queued, iss_ready1=1, iss_ready2=0 -> oldest fires; 2nd remains on port2, becomes port1 next cycle.
// - Entry waiting on r5, wb_dest2=5 -> rdy set; issues next cycle. wb_dest=0 wakes nothing.
// - Fill to DEPTH-1 -> disp_ready=0; dispatch ignored; count unchanged. After 1 fire -> disp_ready=1 next cycle.
// - Dispatch src r7 same cycle sel_dest1=7 -> entry stored ready; issues 1 cycle later.
// - flush with 6 entries and iss_ready=1 -> sel_dest=0 that cycle; next cycle count=0, iss_valid=0, disp_ready=1.

Source files
------------

// File: rtl/issue_queue.sv
// Dual-dispatch, dual-issue age-ordered issue queue: selects the 2 oldest ready entries combinationally from state,
// compacts survivors at the edge and appends dispatches behind them; disp_ready drops once fewer than 2 slots remain.
module issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 5,
  parameter int PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  output logic                 disp_ready,
  input  logic                 disp_valid1,
  input  logic                 disp_valid2,
  input  logic [ADDR_W-1:0]    disp_src1_1,
  input  logic [ADDR_W-1:0]    disp_src1_2,
  input  logic [ADDR_W-1:0]    disp_src2_1,
  input  logic [ADDR_W-1:0]    disp_src2_2,
  input  logic                 disp_rdy1_1,
  input  logic                 disp_rdy1_2,
  input  logic                 disp_rdy2_1,
  input  logic                 disp_rdy2_2,
  input  logic [ADDR_W-1:0]    disp_dest1,
  input  logic [ADDR_W-1:0]    disp_dest2,
  input  logic                 disp_we1,
  input  logic                 disp_we2,
  input  logic [PAYLOAD_W-1:0] disp_payload1,
  input  logic [PAYLOAD_W-1:0] disp_payload2,
  output logic                 iss_valid1,
  output logic                 iss_valid2,
  input  logic                 iss_ready1,
  input  logic                 iss_ready2,
  output logic [PAYLOAD_W-1:0] iss_payload1,
  output logic [PAYLOAD_W-1:0] iss_payload2,
  output logic [ADDR_W-1:0]    sel_dest1,
  output logic [ADDR_W-1:0]    sel_dest2,
  input  logic [ADDR_W-1:0]    wb_dest1,
  input  logic [ADDR_W-1:0]    wb_dest2
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     e_vld, e_rdy1, e_rdy2, e_we;
  logic [ADDR_W-1:0]    e_src1 [DEPTH];
  logic [ADDR_W-1:0]    e_src2 [DEPTH];
  logic [ADDR_W-1:0]    e_dest [DEPTH];
  logic [PAYLOAD_W-1:0] e_pay  [DEPTH];
  logic [CW-1:0]        count;

  logic [DEPTH-1:0]     n_vld, n_rdy1, n_rdy2, n_we;
  logic [ADDR_W-1:0]    n_src1 [DEPTH];
  logic [ADDR_W-1:0]    n_src2 [DEPTH];
  logic [ADDR_W-1:0]    n_dest [DEPTH];
  logic [PAYLOAD_W-1:0] n_pay  [DEPTH];
  logic [CW-1:0]        count_n;

  logic                 found1, found2, fire1, fire2, kill, acc1, acc2;
  logic [IW-1:0]        idx1, idx2, wp;
  logic [4*ADDR_W-1:0]  wake_set;

  // Source reg 0 never waits; a zero in the wake set therefore only re-wakes reg 0.
  function automatic logic woke(input logic [ADDR_W-1:0] s, input logic r,
                                input logic [4*ADDR_W-1:0] w);
    logic hit;
    hit = r || (s == '0);
    for (int k = 0; k < 4; k++)
      if (s == w[k*ADDR_W +: ADDR_W]) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    found1 = 1'b0;
    found2 = 1'b0;
    idx1   = '0;
    idx2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_vld[i] && e_rdy1[i] && e_rdy2[i]) begin
        if (!found1) begin
          found1 = 1'b1;
          idx1   = IW'(i);
        end else if (!found2) begin
          found2 = 1'b1;
          idx2   = IW'(i);
        end
      end
    end
  end

  assign kill         = reset || flush;
  assign iss_valid1   = found1;
  assign iss_valid2   = found2;
  assign iss_payload1 = found1 ? e_pay[idx1] : '0;
  assign iss_payload2 = found2 ? e_pay[idx2] : '0;
  assign fire1        = found1 && iss_ready1 && !kill;
  assign fire2        = found2 && iss_ready2 && !kill;
  assign sel_dest1    = (fire1 && e_we[idx1]) ? e_dest[idx1] : '0;
  assign sel_dest2    = (fire2 && e_we[idx2]) ? e_dest[idx2] : '0;
  assign wake_set     = {sel_dest1, sel_dest2, wb_dest1, wb_dest2};

  assign disp_ready = (count <= CW'(DEPTH - 2));
  assign acc1       = disp_ready && disp_valid1 && !kill;
  assign acc2       = acc1 && disp_valid2;
  assign count_n    = kill ? '0
                    : count - CW'(fire1) - CW'(fire2) + CW'(acc1) + CW'(acc2);

  // Rebuild the entry array every cycle: survivors packed from 0, then new insts; the rest zeroed.
  always_comb begin
    n_vld  = '0;
    n_rdy1 = '0;
    n_rdy2 = '0;
    n_we   = '0;
    wp     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_src1[i] = '0;
      n_src2[i] = '0;
      n_dest[i] = '0;
      n_pay[i]  = '0;
    end
    if (!kill) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_vld[i] && !(fire1 && idx1 == IW'(i)) && !(fire2 && idx2 == IW'(i))) begin
          n_vld[wp]  = 1'b1;
          n_src1[wp] = e_src1[i];
          n_src2[wp] = e_src2[i];
          n_rdy1[wp] = woke(e_src1[i], e_rdy1[i], wake_set);
          n_rdy2[wp] = woke(e_src2[i], e_rdy2[i], wake_set);
          n_dest[wp] = e_dest[i];
          n_we[wp]   = e_we[i];
          n_pay[wp]  = e_pay[i];
          wp         = wp + 1'b1;
        end
      end
      if (acc1) begin
        n_vld[wp]  = 1'b1;
        n_src1[wp] = disp_src1_1;
        n_src2[wp] = disp_src1_2;
        n_rdy1[wp] = woke(disp_src1_1, disp_rdy1_1, wake_set);
        n_rdy2[wp] = woke(disp_src1_2, disp_rdy1_2, wake_set);
        n_dest[wp] = disp_dest1;
        n_we[wp]   = disp_we1;
        n_pay[wp]  = disp_payload1;
        wp         = wp + 1'b1;
      end
      if (acc2) begin
        n_vld[wp]  = 1'b1;
        n_src1[wp] = disp_src2_1;
        n_src2[wp] = disp_src2_2;
        n_rdy1[wp] = woke(disp_src2_1, disp_rdy2_1, wake_set);
        n_rdy2[wp] = woke(disp_src2_2, disp_rdy2_2, wake_set);
        n_dest[wp] = disp_dest2;
        n_we[wp]   = disp_we2;
        n_pay[wp]  = disp_payload2;
      end
    end
  end

  // Reset and flush both flow through kill, which empties the next-state image.
  always_ff @(posedge clk) begin
    count  <= count_n;
    e_vld  <= n_vld;
    e_rdy1 <= n_rdy1;
    e_rdy2 <= n_rdy2;
    e_we   <= n_we;
    e_src1 <= n_src1;
    e_src2 <= n_src2;
    e_dest <= n_dest;
    e_pay  <= n_pay;
  end
endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed vector table, hand-written full/flush sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_issue_queue;
  localparam int DEPTH = 8, ADDR_W = 5, PAYLOAD_W = 64;

  logic clk = 1'b0;
  logic reset, flush, disp_ready, disp_valid1, disp_valid2;
  logic [ADDR_W-1:0] disp_src1_1, disp_src1_2, disp_src2_1, disp_src2_2, disp_dest1, disp_dest2;
  logic disp_rdy1_1, disp_rdy1_2, disp_rdy2_1, disp_rdy2_2, disp_we1, disp_we2;
  logic [PAYLOAD_W-1:0] disp_payload1, disp_payload2, iss_payload1, iss_payload2;
  logic iss_valid1, iss_valid2, iss_ready1, iss_ready2;
  logic [ADDR_W-1:0] sel_dest1, sel_dest2, wb_dest1, wb_dest2;

  issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .disp_ready(disp_ready),
    .disp_valid1(disp_valid1), .disp_valid2(disp_valid2),
    .disp_src1_1(disp_src1_1), .disp_src1_2(disp_src1_2),
    .disp_src2_1(disp_src2_1), .disp_src2_2(disp_src2_2),
    .disp_rdy1_1(disp_rdy1_1), .disp_rdy1_2(disp_rdy1_2),
    .disp_rdy2_1(disp_rdy2_1), .disp_rdy2_2(disp_rdy2_2),
    .disp_dest1(disp_dest1), .disp_dest2(disp_dest2),
    .disp_we1(disp_we1), .disp_we2(disp_we2),
    .disp_payload1(disp_payload1), .disp_payload2(disp_payload2),
    .iss_valid1(iss_valid1), .iss_valid2(iss_valid2),
    .iss_ready1(iss_ready1), .iss_ready2(iss_ready2),
    .iss_payload1(iss_payload1), .iss_payload2(iss_payload2),
    .sel_dest1(sel_dest1), .sel_dest2(sel_dest2),
    .wb_dest1(wb_dest1), .wb_dest2(wb_dest2)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: a plain age-ordered list ----------------
  typedef struct {
    logic [ADDR_W-1:0]    s1, s2, dest;
    logic                 r1, r2, we;
    logic [PAYLOAD_W-1:0] pay;
  } ent_t;

  ent_t mq[$];
  logic x_v1, x_v2, x_dr, x_f1, x_f2;
  int   x_i1, x_i2;
  logic [PAYLOAD_W-1:0] x_p1, x_p2;
  logic [ADDR_W-1:0] x_sd1, x_sd2;

  function automatic logic in_w(input logic [ADDR_W-1:0] s);
    return (s == 0) || (s == x_sd1) || (s == x_sd2) || (s == wb_dest1) || (s == wb_dest2);
  endfunction

  function automatic void model_eval();
    x_v1 = 1'b0; x_v2 = 1'b0; x_i1 = 0; x_i2 = 0; x_p1 = '0; x_p2 = '0;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].r1 && mq[i].r2) begin
        if (!x_v1) begin x_v1 = 1'b1; x_i1 = i; x_p1 = mq[i].pay; end
        else if (!x_v2) begin x_v2 = 1'b1; x_i2 = i; x_p2 = mq[i].pay; end
      end
    end
    x_dr  = (mq.size() <= DEPTH - 2);
    x_f1  = x_v1 && iss_ready1 && !flush && !reset;
    x_f2  = x_v2 && iss_ready2 && !flush && !reset;
    x_sd1 = (x_f1 && mq[x_i1].we) ? mq[x_i1].dest : '0;
    x_sd2 = (x_f2 && mq[x_i2].we) ? mq[x_i2].dest : '0;
  endfunction

  // Checks the current cycle against the model, then advances both across one clock edge.
  task automatic tick();
    ent_t nq[$];
    ent_t e;
    #1;
    model_eval();
    chk("iss_valid1", 64'(iss_valid1), 64'(x_v1));
    chk("iss_valid2", 64'(iss_valid2), 64'(x_v2));
    if (x_v1) chk("iss_payload1", iss_payload1, x_p1);
    if (x_v2) chk("iss_payload2", iss_payload2, x_p2);
    chk("sel_dest1", 64'(sel_dest1), 64'(x_sd1));
    chk("sel_dest2", 64'(sel_dest2), 64'(x_sd2));
    chk("disp_ready", 64'(disp_ready), 64'(x_dr));
    if (!(reset || flush)) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!((x_f1 && i == x_i1) || (x_f2 && i == x_i2))) begin
          e = mq[i];
          e.r1 = e.r1 | in_w(e.s1);
          e.r2 = e.r2 | in_w(e.s2);
          nq.push_back(e);
        end
      end
      if (x_dr && disp_valid1) begin
        e.s1 = disp_src1_1; e.s2 = disp_src1_2; e.dest = disp_dest1; e.we = disp_we1;
        e.r1 = disp_rdy1_1 | in_w(disp_src1_1); e.r2 = disp_rdy1_2 | in_w(disp_src1_2);
        e.pay = disp_payload1;
        nq.push_back(e);
        if (disp_valid2) begin
          e.s1 = disp_src2_1; e.s2 = disp_src2_2; e.dest = disp_dest2; e.we = disp_we2;
          e.r1 = disp_rdy2_1 | in_w(disp_src2_1); e.r2 = disp_rdy2_2 | in_w(disp_src2_2);
          e.pay = disp_payload2;
          nq.push_back(e);
        end
      end
    end
    @(posedge clk);
    mq = nq;
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct { int v, s1, r1, s2, r2, d, we, p; } slot_t;
  typedef struct {
    slot_t a, b;
    int ir1, ir2, wb1, wb2, fl;
    int ev1, ep1, esd1, ev2, ep2, esd2, edr;
  } vec_t;

  task automatic drive_slots(input slot_t a, input slot_t b);
    disp_valid1 = (a.v != 0); disp_src1_1 = ADDR_W'(a.s1); disp_rdy1_1 = (a.r1 != 0);
    disp_src1_2 = ADDR_W'(a.s2); disp_rdy1_2 = (a.r2 != 0); disp_dest1 = ADDR_W'(a.d);
    disp_we1 = (a.we != 0); disp_payload1 = PAYLOAD_W'(a.p);
    disp_valid2 = (b.v != 0); disp_src2_1 = ADDR_W'(b.s1); disp_rdy2_1 = (b.r1 != 0);
    disp_src2_2 = ADDR_W'(b.s2); disp_rdy2_2 = (b.r2 != 0); disp_dest2 = ADDR_W'(b.d);
    disp_we2 = (b.we != 0); disp_payload2 = PAYLOAD_W'(b.p);
  endtask

  task automatic idle();
    slot_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    drive_slots(z, z);
    iss_ready1 = 1'b0; iss_ready2 = 1'b0;
    wb_dest1 = '0; wb_dest2 = '0; flush = 1'b0; reset = 1'b0;
  endtask

  vec_t tv[14];
  slot_t s0, blk, rdy;

  initial begin
    s0 = '{0, 0, 0, 0, 0, 0, 0, 0};
    //        slot1                          slot2                       ir1 ir2 wb1 wb2 fl  ev1 ep1   sd1 ev2 ep2   sd2 dr
    tv[0]  = '{'{1,1,1,2,1,3,1,'hA},   '{1,3,0,0,0,4,1,'hB},   1, 1, 0, 0, 0,  0, 0,    0,  0, 0,    0,  1};
    tv[1]  = '{s0,                     s0,                     1, 1, 0, 0, 0,  1, 'hA,  3,  0, 0,    0,  1};
    tv[2]  = '{s0,                     s0,                     1, 1, 0, 0, 0,  1, 'hB,  4,  0, 0,    0,  1};
    tv[3]  = '{'{1,1,1,2,1,7,1,'hD},   s0,                     1, 1, 0, 0, 0,  0, 0,    0,  0, 0,    0,  1};
    tv[4]  = '{'{1,7,0,0,0,9,1,'hE},   s0,                     1, 1, 0, 0, 0,  1, 'hD,  7,  0, 0,    0,  1};
    tv[5]  = '{s0,                     s0,                     1, 1, 0, 0, 0,  1, 'hE,  9,  0, 0,    0,  1};
    tv[6]  = '{'{1,5,0,6,1,10,0,'hF},  s0,                     1, 1, 0, 0, 0,  0, 0,    0,  0, 0,    0,  1};
    tv[7]  = '{s0,                     s0,                     1, 1, 0, 5, 0,  0, 0,    0,  0, 0,    0,  1};
    tv[8]  = '{s0,                     s0,                     1, 1, 0, 0, 0,  1, 'hF,  0,  0, 0,    0,  1};
    tv[9]  = '{'{1,1,1,2,1,11,1,'h10}, '{1,3,1,4,1,12,1,'h11}, 0, 0, 0, 0, 0,  0, 0,    0,  0, 0,    0,  1};
    tv[10] = '{'{1,1,1,1,1,13,1,'h12}, s0,                     0, 0, 0, 0, 0,  1, 'h10, 0,  1, 'h11, 0,  1};
    tv[11] = '{s0,                     s0,                     1, 0, 0, 0, 0,  1, 'h10, 11, 1, 'h11, 0,  1};
    tv[12] = '{s0,                     s0,                     1, 1, 0, 0, 0,  1, 'h11, 12, 1, 'h12, 13, 1};
    tv[13] = '{s0,                     s0,                     1, 1, 0, 0, 0,  0, 0,    0,  0, 0,    0,  1};

    idle();
    reset = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("reset iss_valid1", 64'(iss_valid1), 64'(0));
    chk("reset iss_valid2", 64'(iss_valid2), 64'(0));
    chk("reset sel_dest1", 64'(sel_dest1), 64'(0));
    chk("reset sel_dest2", 64'(sel_dest2), 64'(0));
    chk("reset disp_ready", 64'(disp_ready), 64'(1));
    chk("reset iss_payload1", iss_payload1, 64'(0));
    chk("reset iss_payload2", iss_payload2, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      drive_slots(tv[k].a, tv[k].b);
      iss_ready1 = (tv[k].ir1 != 0); iss_ready2 = (tv[k].ir2 != 0);
      wb_dest1 = ADDR_W'(tv[k].wb1); wb_dest2 = ADDR_W'(tv[k].wb2);
      flush = (tv[k].fl != 0);
      #1;
      chk($sformatf("row%0d iss_valid1", k), 64'(iss_valid1), 64'(tv[k].ev1));
      if (tv[k].ev1 != 0) chk($sformatf("row%0d iss_payload1", k), iss_payload1, 64'(tv[k].ep1));
      chk($sformatf("row%0d sel_dest1", k), 64'(sel_dest1), 64'(tv[k].esd1));
      chk($sformatf("row%0d iss_valid2", k), 64'(iss_valid2), 64'(tv[k].ev2));
      if (tv[k].ev2 != 0) chk($sformatf("row%0d iss_payload2", k), iss_payload2, 64'(tv[k].ep2));
      chk($sformatf("row%0d sel_dest2", k), 64'(sel_dest2), 64'(tv[k].esd2));
      chk($sformatf("row%0d disp_ready", k), 64'(disp_ready), 64'(tv[k].edr));
      tick();
    end

    // Fill to DEPTH-1, try a dispatch while full, fire one, then flush with 6 ready entries.
    idle();
    blk = '{1, 31, 0, 31, 0, 20, 1, 'h30};
    for (int k = 0; k < 3; k++) begin
      drive_slots(blk, blk);
      tick();
    end
    rdy = '{1, 1, 1, 2, 1, 21, 1, 'h77};
    drive_slots(rdy, s0);
    #1 chk("six entries disp_ready", 64'(disp_ready), 64'(1));
    tick();
    rdy = '{1, 0, 1, 0, 1, 22, 1, 'h99};
    drive_slots(rdy, rdy);
    #1 chk("full disp_ready", 64'(disp_ready), 64'(0));
    chk("full iss_payload1", iss_payload1, 64'h77);
    tick();
    idle();
    iss_ready1 = 1'b1;
    #1 chk("full fire sel_dest1", 64'(sel_dest1), 64'(21));
    chk("fire cycle disp_ready", 64'(disp_ready), 64'(0));
    tick();
    idle();
    wb_dest1 = 5'd31;
    #1 chk("after fire disp_ready", 64'(disp_ready), 64'(1));
    chk("ignored dispatch absent", 64'(iss_valid1), 64'(0));
    tick();
    idle();
    flush = 1'b1; iss_ready1 = 1'b1; iss_ready2 = 1'b1;
    drive_slots(rdy, rdy);
    #1 chk("preflush iss_valid1", 64'(iss_valid1), 64'(1));
    chk("flush sel_dest1", 64'(sel_dest1), 64'(0));
    chk("flush sel_dest2", 64'(sel_dest2), 64'(0));
    tick();
    idle();
    iss_ready1 = 1'b1;
    #1 chk("postflush iss_valid1", 64'(iss_valid1), 64'(0));
    chk("postflush iss_valid2", 64'(iss_valid2), 64'(0));
    chk("postflush disp_ready", 64'(disp_ready), 64'(1));
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      disp_valid1 = ($urandom_range(0, 1) == 1);
      disp_valid2 = disp_valid1 && ($urandom_range(0, 1) == 1);
      disp_src1_1 = ADDR_W'($urandom_range(0, 7)); disp_src1_2 = ADDR_W'($urandom_range(0, 7));
      disp_src2_1 = ADDR_W'($urandom_range(0, 7)); disp_src2_2 = ADDR_W'($urandom_range(0, 7));
      disp_rdy1_1 = ($urandom_range(0, 1) == 1); disp_rdy1_2 = ($urandom_range(0, 1) == 1);
      disp_rdy2_1 = ($urandom_range(0, 1) == 1); disp_rdy2_2 = ($urandom_range(0, 1) == 1);
      disp_dest1 = ADDR_W'($urandom_range(0, 7)); disp_dest2 = ADDR_W'($urandom_range(0, 7));
      disp_we1 = ($urandom_range(0, 3) != 0); disp_we2 = ($urandom_range(0, 3) != 0);
      disp_payload1 = {$urandom, $urandom}; disp_payload2 = {$urandom, $urandom};
      iss_ready1 = ($urandom_range(0, 3) != 0); iss_ready2 = ($urandom_range(0, 3) != 0);
      wb_dest1 = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(1, 7)) : '0;
      wb_dest2 = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(1, 7)) : '0;
      flush = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    idle();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
